// File: rtl/cpu_defs_pkg.sv
// Shared fetch-side types and defaults for the instruction fetch queue.
package cpu_defs;

    localparam int unsigned IFQ_DEPTH = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_queue_regfile.sv
// DEPTH-entry instruction storage: two write ports, two combinational read ports, no data reset.
module ifq_regfile
    import cpu_defs::*;
#(
    parameter int unsigned DEPTH     = IFQ_DEPTH,
    parameter int unsigned PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we0,
    input  logic [PTR_WIDTH-1:0] waddr0,
    input  fetch_entry_t         wdata0,
    input  logic                 we1,
    input  logic [PTR_WIDTH-1:0] waddr1,
    input  fetch_entry_t         wdata1,
    input  logic [PTR_WIDTH-1:0] raddr0,
    output fetch_entry_t         rdata0,
    input  logic [PTR_WIDTH-1:0] raddr1,
    output fetch_entry_t         rdata1
);

    fetch_entry_t mem_q [DEPTH];

    // The two write addresses are always distinct (tail and tail+1).
    always_ff @(posedge clk) begin
        if (we0) mem_q[waddr0] <= wdata0;
        if (we1) mem_q[waddr1] <= wdata1;
    end

    assign rdata0 = mem_q[raddr0];
    assign rdata1 = mem_q[raddr1];

endmodule

// File: rtl/instr_fetch_queue.sv
// Circular instruction queue between I-cache and decode: splits 64-bit packets, presents two per cycle.
// Optional IFQ_BYPASS_EN: incoming instructions drive out_* in the same cycle when the queue is empty.
module instr_fetch_queue
    import cpu_defs::*;
#(
    parameter  int unsigned DEPTH     = IFQ_DEPTH,
    localparam int unsigned PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               fetch_valid,
    input  logic [31:0]        fetch_pc,
    input  logic [63:0]        fetch_data,
    output logic               fetch_ready,
    input  logic [1:0]         pop_cnt,
    output logic [1:0]         out_valid,
    output logic [63:0]        out_instr,
    output logic [63:0]        out_pc,
    output logic [PTR_WIDTH:0] count
);

    localparam int unsigned CW = PTR_WIDTH + 1;

    logic [PTR_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 push, bypass, we0, we1;
    logic [1:0]           push_n, pop_n, avail;
    fetch_entry_t         in0, in1, rd0, rd1, wd0, wd1, slot0, slot1;
    logic                 unused_pc_bits;

    assign unused_pc_bits = ^fetch_pc[1:0];

    // Packet split: slot 0 of a PC[2]=1 packet is the upper word.
    always_comb begin
        in0.pc    = {fetch_pc[31:2], 2'b00};
        in0.instr = fetch_pc[2] ? fetch_data[63:32] : fetch_data[31:0];
        in1.pc    = {fetch_pc[31:2], 2'b00} + 32'd4;
        in1.instr = fetch_data[63:32];
    end

    assign fetch_ready = (count_q <= CW'(DEPTH - 2));
    assign push        = fetch_valid & fetch_ready & ~flush;
    assign push_n      = push ? (fetch_pc[2] ? 2'd1 : 2'd2) : 2'd0;

    always_comb begin
        bypass = 1'b0;
`ifdef IFQ_BYPASS_EN
        bypass = push & (count_q == '0);
`endif
    end

    // Output view, pop clamp and pointer/count update.
    always_comb begin
        avail     = (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];
        out_valid = {count_q >= CW'(2), count_q != '0};
        slot0     = rd0;
        slot1     = rd1;
        if (bypass) begin
            avail     = push_n;
            out_valid = {push_n == 2'd2, 1'b1};
            slot0     = in0;
            slot1     = in1;
        end
        pop_n     = (pop_cnt > avail) ? avail : pop_cnt;
        out_instr = {slot1.instr, slot0.instr};
        out_pc    = {slot1.pc, slot0.pc};

        head_d  = head_q + (bypass ? '0 : PTR_WIDTH'(pop_n));
        tail_d  = tail_q + PTR_WIDTH'(push_n) - (bypass ? PTR_WIDTH'(pop_n) : '0);
        count_d = count_q + CW'(push_n) - CW'(pop_n);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // In bypass only the instructions decode did not consume are written.
    always_comb begin
        we0 = push;
        we1 = push & ~fetch_pc[2];
        wd0 = in0;
        wd1 = in1;
        if (bypass) begin
            if (pop_n != 2'd0) wd0 = in1;
            we0 = push_n > pop_n;
            we1 = (push_n == 2'd2) && (pop_n == 2'd0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;

    ifq_regfile #(
        .DEPTH    (DEPTH),
        .PTR_WIDTH(PTR_WIDTH)
    ) u_regfile (
        .clk   (clk),
        .we0   (we0),
        .waddr0(tail_q),
        .wdata0(wd0),
        .we1   (we1),
        .waddr1(tail_q + PTR_WIDTH'(1)),
        .wdata1(wd1),
        .raddr0(head_q),
        .rdata0(rd0),
        .raddr1(head_q + PTR_WIDTH'(1)),
        .rdata1(rd1)
    );

`ifndef SYNTHESIS
    a_pop_legal: assert property (@(posedge clk) disable iff (rst)
        (32'(pop_cnt) <= $countones(out_valid)));
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: stimulus queues expected entries, a negedge monitor checks them.
module tb_instr_fetch_queue;
    import cpu_defs::*;

    localparam int unsigned DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic [63:0] fetch_data = '0;
    logic        fetch_ready;
    logic [1:0]  pop_cnt = '0;
    logic [1:0]  out_valid;
    logic [63:0] out_instr;
    logic [63:0] out_pc;
    logic [4:0]  count;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    fetch_entry_t q[$];
    fetch_entry_t pend[$];

    always #5 clk = ~clk;

    instr_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .fetch_valid(fetch_valid),
        .fetch_pc   (fetch_pc),
        .fetch_data (fetch_data),
        .fetch_ready(fetch_ready),
        .pop_cnt    (pop_cnt),
        .out_valid  (out_valid),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .count      (count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus and queue what an accepted push should produce.
    task automatic cyc(input logic fv, input logic [31:0] pc, input logic [63:0] d,
                       input logic [1:0] pop, input logic fl);
        logic [31:0] pa;
        @(posedge clk);
        #1;
        fetch_valid = fv;
        fetch_pc    = pc;
        fetch_data  = d;
        pop_cnt     = pop;
        flush       = fl;
        pa = {pc[31:2], 2'b00};
        if (fv && !fl && q.size() <= DEPTH - 2) begin
            if (pc[2]) begin
                pend.push_back('{pc: pa, instr: d[63:32]});
            end else begin
                pend.push_back('{pc: pa, instr: d[31:0]});
                pend.push_back('{pc: pa + 32'd4, instr: d[63:32]});
            end
        end
    endtask

    // Monitor: compare presented state against the model, then apply this cycle's ops.
    always @(negedge clk) begin
        fetch_entry_t view[$];
        if (!rst && mon_en) begin
            view = q;
`ifdef IFQ_BYPASS_EN
            if (q.size() == 0) view = pend;
`endif
            chk("count", 32'(count), 32'(q.size()));
            chk("fetch_ready", 32'(fetch_ready), 32'(q.size() <= DEPTH - 2));
            chk("out_valid", 32'(out_valid), {30'd0, view.size() >= 2, view.size() >= 1});
            if (view.size() >= 1) begin
                chk("slot0_pc", out_pc[31:0], view[0].pc);
                chk("slot0_instr", out_instr[31:0], view[0].instr);
            end
            if (view.size() >= 2) begin
                chk("slot1_pc", out_pc[63:32], view[1].pc);
                chk("slot1_instr", out_instr[63:32], view[1].instr);
            end
            if (flush) begin
                q.delete();
            end else begin
                foreach (pend[i]) q.push_back(pend[i]);
                repeat (pop_cnt) if (q.size() > 0) void'(q.pop_front());
            end
            pend.delete();
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #3;
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_fetch_ready", 32'(fetch_ready), 32'd1);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        // Basic two- and one-instruction packets
        cyc(1'b1, 32'h1000, 64'h22222222_11111111, 2'd0, 1'b0);
        cyc(1'b0, 32'h0, 64'h0, 2'd2, 1'b0);
        cyc(1'b1, 32'h2004, 64'hAAAA0001_DEADBEEF, 2'd0, 1'b0);
        cyc(1'b0, 32'h0, 64'h0, 2'd1, 1'b0);

        // Fill to full, push ignored at full, pop 2 from full, drain
        for (int i = 0; i < 8; i++)
            cyc(1'b1, 32'h5000 + 32'(8 * i), {32'hB000_0000 + 32'(i), 32'hA000_0000 + 32'(i)}, 2'd0, 1'b0);
        cyc(1'b1, 32'h5040, 64'hFFFF0001_FFFF0000, 2'd0, 1'b0);
        cyc(1'b1, 32'h5048, 64'hFFFF0003_FFFF0002, 2'd2, 1'b0);
        cyc(1'b0, 32'h0, 64'h0, 2'd0, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b0, 32'h0, 64'h0, 2'd2, 1'b0);

        // Odd-aligned streaming across several pointer wraps
        cyc(1'b1, 32'h2FFC, 64'h12345678_0BADF00D, 2'd0, 1'b0);
        cyc(1'b1, 32'h3000, 64'hC0003004_C0003000, 2'd0, 1'b0);
        for (int k = 1; k <= 24; k++) begin
            logic [31:0] p;
            p = 32'h3000 + 32'(8 * k);
            cyc(1'b1, p, {~(p + 32'd4), ~p}, 2'd2, 1'b0);
        end
        cyc(1'b0, 32'h0, 64'h0, 2'd2, 1'b0);
        cyc(1'b0, 32'h0, 64'h0, 2'd1, 1'b0);

        // Flush at count 5 with push and pop pending
        cyc(1'b1, 32'h6000, 64'h60000004_60000000, 2'd0, 1'b0);
        cyc(1'b1, 32'h6008, 64'h6000000C_60000008, 2'd0, 1'b0);
        cyc(1'b1, 32'h6014, 64'h60000014_60000010, 2'd0, 1'b0);
        cyc(1'b1, 32'h6100, 64'h61000004_61000000, 2'd2, 1'b1);
        cyc(1'b1, 32'h7000, 64'h70000004_70000000, 2'd0, 1'b0);
        cyc(1'b1, 32'h7100, 64'h71000004_71000000, 2'd1, 1'b0);

        // Asynchronous reset mid-operation
        @(posedge clk);
        #3;
        rst = 1'b1;
        fetch_valid = 1'b0;
        pop_cnt = 2'd0;
        flush = 1'b0;
        q.delete();
        pend.delete();
        #1;
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b1, 32'h7200, 64'h72000004_72000000, 2'd0, 1'b0);
        cyc(1'b0, 32'h0, 64'h0, 2'd2, 1'b0);

`ifdef IFQ_BYPASS_EN
        // Same-cycle consumption from an empty queue
        cyc(1'b1, 32'h4000, 64'h40000004_40000000, 2'd1, 1'b0);
        cyc(1'b0, 32'h0, 64'h0, 2'd0, 1'b0);
        cyc(1'b0, 32'h0, 64'h0, 2'd1, 1'b0);
`endif

        cyc(1'b0, 32'h0, 64'h0, 2'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
